// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low patterns, recovered-code payload and pattern-to-hex encoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic       blank;
    logic       ok;
    logic [3:0] hex;
  } seg7_code_t;

  // Blank is a legal code with hex 0; anything not in the table is flagged not-ok.
  function automatic seg7_code_t seg7_encode(input logic [6:0] seg_n);
    seg7_code_t c;
    c = '{blank: 1'b0, ok: 1'b1, hex: 4'h0};
    case (seg_n)
      SEG_0:     c.hex = 4'h0;
      SEG_1:     c.hex = 4'h1;
      SEG_2:     c.hex = 4'h2;
      SEG_3:     c.hex = 4'h3;
      SEG_4:     c.hex = 4'h4;
      SEG_5:     c.hex = 4'h5;
      SEG_6:     c.hex = 4'h6;
      SEG_7:     c.hex = 4'h7;
      SEG_8:     c.hex = 4'h8;
      SEG_9:     c.hex = 4'h9;
      SEG_A:     c.hex = 4'hA;
      SEG_B:     c.hex = 4'hB;
      SEG_C:     c.hex = 4'hC;
      SEG_D:     c.hex = 4'hD;
      SEG_E:     c.hex = 4'hE;
      SEG_F:     c.hex = 4'hF;
      SEG_BLANK: c.blank = 1'b1;
      default:   c.ok = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Multiplexed 7-segment display bus plus the recovered per-digit result bus.
interface seg7_scan_capture_if #(
  parameter int unsigned NUM_DIGITS = 6
);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic [6:0]              seg_n_i;
  logic [NUM_DIGITS-1:0]   an_n_i;
  logic [4*NUM_DIGITS-1:0] digit_o;
  logic [NUM_DIGITS-1:0]   blank_o;
  logic [NUM_DIGITS-1:0]   valid_o;
  logic                    upd_o;
  logic [IDX_W-1:0]        upd_idx_o;
  logic                    err_o;
  logic [IDX_W-1:0]        err_idx_o;

  modport master (
    output seg_n_i, an_n_i,
    input  digit_o, blank_o, valid_o, upd_o, upd_idx_o, err_o, err_idx_o
  );

  modport slave (
    input  seg_n_i, an_n_i,
    output digit_o, blank_o, valid_o, upd_o, upd_idx_o, err_o, err_idx_o
  );
endinterface

// File: rtl/seg7_hex_encode.sv
// Combinational lookup of an active-low segment pattern into a recovered hex code.
module seg7_hex_encode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output seg7_code_t code_c
);
  assign code_c = seg7_encode(seg_n);
endmodule

// File: rtl/seg7_scan_capture.sv
// Recovers the hex value on each digit of a scanned active-low 7-seg bus and commits it once stable.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 6,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned STABLE_SCANS  = 3
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_capture_if.slave bus
);
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned SYNC_W  = NUM_DIGITS + 7;
  localparam int unsigned CNT_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned MATCH_W = $clog2(STABLE_SCANS + 1);

  logic [SYNC_W-1:0]     sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0]      settle_q;
  logic [NUM_DIGITS-1:0] an_act_c;
  logic [6:0]            seg_c;
  logic                  onehot_c, stable_c, sample_c, commit_c;
  logic [IDX_W-1:0]      idx_c;
  seg7_code_t            code_c;
  logic [4:0]            cur_c;
  logic [MATCH_W-1:0]    match_nxt_c;

  logic [4:0]            last_q  [NUM_DIGITS];
  logic [MATCH_W-1:0]    match_q [NUM_DIGITS];
  logic [3:0]            hex_q   [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank_q, valid_q;
  logic                  upd_q, err_q;
  logic [IDX_W-1:0]      upd_idx_q, err_idx_q;
  logic [4*NUM_DIGITS-1:0] digit_c;

  // Two-stage synchronizer plus one history stage for the dwell-stability compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= {bus.an_n_i, bus.seg_n_i};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign an_act_c = ~sync2_q[SYNC_W-1:7];
  assign seg_c    = sync2_q[6:0];
  assign onehot_c = (|an_act_c) && !(|(an_act_c & (an_act_c - NUM_DIGITS'(1))));
  assign stable_c = (sync2_q == prev_q) && onehot_c;
  // One sample per dwell: only on the cycle the settle count reaches its target.
  assign sample_c = stable_c && (settle_q == CNT_W'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= '0;
    end else if (!stable_c) begin
      settle_q <= '0;
    end else if (settle_q != CNT_W'(SETTLE_CYCLES)) begin
      settle_q <= settle_q + CNT_W'(1);
    end
  end

  always_comb begin
    idx_c = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (an_act_c[k]) idx_c = IDX_W'(k);
    end
  end

  seg7_hex_encode u_enc (
    .seg_n  (seg_c),
    .code_c (code_c)
  );

  always_comb begin
    cur_c       = {code_c.blank, code_c.hex};
    match_nxt_c = MATCH_W'(1);
    if (cur_c == last_q[idx_c]) begin
      match_nxt_c = (match_q[idx_c] == MATCH_W'(STABLE_SCANS)) ? match_q[idx_c]
                                                              : match_q[idx_c] + MATCH_W'(1);
    end
    commit_c = sample_c && code_c.ok && (match_nxt_c == MATCH_W'(STABLE_SCANS)) &&
               (!valid_q[idx_c] || (cur_c != {blank_q[idx_c], hex_q[idx_c]}));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        last_q[k]  <= '0;
        match_q[k] <= '0;
        hex_q[k]   <= '0;
      end
      blank_q   <= '0;
      valid_q   <= '0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
      upd_idx_q <= '0;
      err_idx_q <= '0;
    end else begin
      upd_q <= 1'b0;
      err_q <= 1'b0;
      if (sample_c) begin
        if (!code_c.ok) begin
          err_q          <= 1'b1;
          err_idx_q      <= idx_c;
          match_q[idx_c] <= '0;
        end else begin
          last_q[idx_c]  <= cur_c;
          match_q[idx_c] <= match_nxt_c;
          if (commit_c) begin
            hex_q[idx_c]   <= code_c.hex;
            blank_q[idx_c] <= code_c.blank;
            valid_q[idx_c] <= 1'b1;
            upd_q          <= 1'b1;
            upd_idx_q      <= idx_c;
          end
        end
      end
    end
  end

  always_comb begin
    digit_c = '0;
    for (int k = 0; k < NUM_DIGITS; k++) digit_c[4*k +: 4] = hex_q[k];
  end

  assign bus.digit_o   = digit_c;
  assign bus.blank_o   = blank_q;
  assign bus.valid_o   = valid_q;
  assign bus.upd_o     = upd_q;
  assign bus.upd_idx_o = upd_idx_q;
  assign bus.err_o     = err_q;
  assign bus.err_idx_o = err_idx_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with a per-dwell behavioural model checked every cycle.
module tb_seg7_scan_capture;
  localparam int unsigned ND = 6;
  localparam int unsigned SC = 4;
  localparam int unsigned SS = 3;
  localparam logic [6:0] HEX_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  seg7_scan_capture_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_capture #(
    .NUM_DIGITS    (ND),
    .SETTLE_CYCLES (SC),
    .STABLE_SCANS  (SS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         idx;
    logic [6:0] seg;
  } ev_t;

  ev_t evq[$];
  ev_t ev_cur;

  // Model state per digit: last code (blank*16+hex), match count, committed value.
  int   m_last  [ND];
  int   m_match [ND];
  int   m_hex   [ND];
  int   m_blank [ND];
  int   m_valid [ND];
  logic exp_upd, exp_err;
  int   exp_upd_idx, exp_err_idx;
  logic [ND+6:0] last_pins;
  logic [6:0]    frame_seg [ND];
  int   upd_cnt = 0, err_cnt = 0, last_upd_idx = 0, last_err_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < ND; k++) begin
      m_last[k] = 0; m_match[k] = 0; m_hex[k] = 0; m_blank[k] = 0; m_valid[k] = 0;
    end
    evq.delete();
    last_pins = '1;
  endtask

  task automatic model_sample(input int idx, input logic [6:0] seg);
    int code;
    code = -1;
    if (seg == 7'h7F) code = 16;
    for (int h = 0; h < 16; h++) if (HEX_TBL[h] == seg) code = h;
    if (code < 0) begin
      exp_err = 1'b1; exp_err_idx = idx; m_match[idx] = 0;
    end else begin
      if (code == m_last[idx]) m_match[idx] = (m_match[idx] >= SS) ? SS : m_match[idx] + 1;
      else begin m_last[idx] = code; m_match[idx] = 1; end
      if (m_match[idx] == SS &&
          (m_valid[idx] == 0 || m_hex[idx] != (code % 16) || m_blank[idx] != (code / 16))) begin
        m_hex[idx] = code % 16; m_blank[idx] = code / 16; m_valid[idx] = 1;
        exp_upd = 1'b1; exp_upd_idx = idx;
      end
    end
  endtask

  function automatic logic [31:0] model_digits();
    logic [31:0] d;
    d = '0;
    for (int k = 0; k < ND; k++) d[4*k +: 4] = 4'(m_hex[k]);
    return d;
  endfunction

  function automatic logic [31:0] model_mask(input int sel);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < ND; k++) m[k] = (sel == 0) ? (m_blank[k] != 0) : (m_valid[k] != 0);
    return m;
  endfunction

  // Every out-of-reset cycle: retire due samples into the model, then compare all outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_upd = 1'b0; exp_err = 1'b0; exp_upd_idx = 0; exp_err_idx = 0;
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        ev_cur = evq.pop_front();
        model_sample(ev_cur.idx, ev_cur.seg);
      end
      check("upd", 32'(bus.upd_o), 32'(exp_upd));
      check("err", 32'(bus.err_o), 32'(exp_err));
      if (exp_upd) check("upd_idx", 32'(bus.upd_idx_o), 32'(exp_upd_idx));
      if (exp_err) check("err_idx", 32'(bus.err_idx_o), 32'(exp_err_idx));
      check("digit", 32'(bus.digit_o), model_digits());
      check("blank", 32'(bus.blank_o), model_mask(0));
      check("valid", 32'(bus.valid_o), model_mask(1));
      if (bus.upd_o) begin upd_cnt++; last_upd_idx = int'(bus.upd_idx_o); end
      if (bus.err_o) begin err_cnt++; last_err_idx = int'(bus.err_idx_o); end
    end
  end

  // Hold one {an,seg} for len cycles; a settled one-hot dwell yields one sample SC+3 edges later.
  task automatic dwell(input logic [ND-1:0] an, input logic [6:0] seg, input int len);
    int   zeros, idx;
    ev_t  ev;
    zeros = 0; idx = 0;
    bus.an_n_i  = an;
    bus.seg_n_i = seg;
    for (int k = 0; k < ND; k++) if (!an[k]) begin zeros++; idx = k; end
    if (zeros == 1 && len >= int'(SC) + 1 && {an, seg} != last_pins) begin
      ev.cyc = cyc + int'(SC) + 3; ev.idx = idx; ev.seg = seg;
      evq.push_back(ev);
    end
    last_pins = {an, seg};
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int len, input int ndig);
    logic [ND-1:0] an;
    for (int k = 0; k < ndig; k++) begin
      an = '1; an[k] = 1'b0;
      dwell(an, frame_seg[k], len);
    end
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    bus.an_n_i  = '1;
    bus.seg_n_i = '1;
    model_clear();
    #1;
    check("rst_digit", 32'(bus.digit_o), 32'h0);
    check("rst_valid", 32'(bus.valid_o), 32'h0);
    check("rst_blank", 32'(bus.blank_o), 32'h0);
    check("rst_pulses", 32'({bus.upd_o, bus.err_o}), 32'h0);
    check("rst_idx", 32'({bus.upd_idx_o, bus.err_idx_o}), 32'h0);
  endtask

  int u0, e0;

  initial begin
    assert_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: scan 1,2,3,4,5,9 for three frames
    frame_seg = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h18};
    repeat (3) frame(8, ND);
    check("t1_digit", 32'(bus.digit_o), 32'h954321);
    check("t1_valid", 32'(bus.valid_o), 32'h3F);
    check("t1_blank", 32'(bus.blank_o), 32'h0);
    check("t1_upd_cnt", 32'(upd_cnt), 32'd6);

    // 2: re-confirming identical frames must not pulse
    u0 = upd_cnt;
    repeat (10) frame(8, ND);
    check("t2_no_upd", 32'(upd_cnt - u0), 32'd0);
    check("t2_digit", 32'(bus.digit_o), 32'h954321);

    // 3: digit 2 blanked
    u0 = upd_cnt;
    frame_seg[2] = 7'h7F;
    repeat (3) frame(8, ND);
    check("t3_upd_cnt", 32'(upd_cnt - u0), 32'd1);
    check("t3_upd_idx", 32'(last_upd_idx), 32'd2);
    check("t3_blank", 32'(bus.blank_o), 32'h04);
    check("t3_digit", 32'(bus.digit_o), 32'h954021);

    // 4: illegal pattern on digit 4, then restore the same value
    u0 = upd_cnt; e0 = err_cnt;
    frame_seg[4] = 7'h7E;
    repeat (3) frame(8, ND);
    check("t4_err_cnt", 32'(err_cnt - e0), 32'd3);
    check("t4_err_idx", 32'(last_err_idx), 32'd4);
    check("t4_digit4", 32'(bus.digit_o[19:16]), 32'h5);
    check("t4_valid", 32'(bus.valid_o), 32'h3F);
    frame_seg[4] = 7'h12;
    repeat (3) frame(8, ND);
    check("t4_no_upd", 32'(upd_cnt - u0), 32'd0);

    // 5: short dwells and multi-hot anodes are ignored
    u0 = upd_cnt; e0 = err_cnt;
    frame_seg = '{7'h00, 7'h00, 7'h7E, 7'h00, 7'h00, 7'h00};
    repeat (4) frame(3, ND);
    dwell(6'b111100, 7'h00, 20);
    dwell(6'b111100, 7'h7E, 20);
    check("t5_no_upd", 32'(upd_cnt - u0), 32'd0);
    check("t5_no_err", 32'(err_cnt - e0), 32'd0);
    check("t5_digit", 32'(bus.digit_o), 32'h954021);

    // 6: reset mid-frame after two matching scans discards history
    frame_seg = '{7'h78, 7'h78, 7'h78, 7'h78, 7'h78, 7'h78};
    repeat (2) frame(8, ND);
    frame(8, 3);
    assert_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    u0 = upd_cnt;
    repeat (2) frame(8, ND);
    check("t6_no_upd", 32'(upd_cnt - u0), 32'd0);
    check("t6_valid0", 32'(bus.valid_o), 32'h0);
    frame(8, ND);
    check("t6_upd_cnt", 32'(upd_cnt - u0), 32'd6);
    check("t6_digit", 32'(bus.digit_o), 32'h777777);
    check("t6_pending", 32'(evq.size()), 32'd0);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
